// File: rtl/uart_status_tx.sv
// uart_status_tx: sends a 4-byte status frame (header, waveform, frequency,
// checksum) as UART 8N1 when requested. The waveform and frequency selections
// are captured when the request is accepted, so later changes to them do not
// alter a frame that is already being sent.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line high, not busy, waiting for report_req
// S_START | start bit (low) for one bit time
// S_DATA  | 8 data bits, LSB first, bit_idx 0..7
// S_STOP  | stop bit (high); next byte or back to idle after byte 3
module uart_status_tx #(
  parameter int CLK_HZ       = 25000000,
  parameter int BIT_RATE     = 9600,
  parameter int CLKS_PER_BIT = CLK_HZ / BIT_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       report_req,
  input  logic [7:0] waveform_sel,
  input  logic [3:0] freq_sel,
  output logic       uart_txd,
  output logic       busy,
  output logic       done
);

  localparam int              BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]      HEADER    = 8'hA5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // A bit time shorter than two cycles cannot hold the baud counter's wrap.
  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_status_tx: CLKS_PER_BIT must be >= 2");
    end
  endgenerate

  logic [1:0]        state_q,    state_d;
  logic [BAUD_W-1:0] baud_q,     baud_d;
  logic [2:0]        bit_idx_q,  bit_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        wave_q,     wave_d;
  logic [3:0]        freq_q,     freq_d;
  logic [7:0]        chk_q,      chk_d;
  logic              done_q,     done_d;
  logic              txd_q,      txd_d;
  logic              bit_end;
  logic [7:0]        cur_byte_d;

  assign bit_end  = (baud_q == BAUD_LAST);
  assign uart_txd = txd_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;

  // Next-state logic: baud counter, bit/byte sequencing and request capture.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    wave_d     = wave_q;
    freq_d     = freq_q;
    chk_d      = chk_q;
    done_d     = 1'b0;

    if (state_q == S_IDLE || bit_end) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + BAUD_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (report_req) begin
          wave_d     = waveform_sel;
          freq_d     = freq_sel;
          chk_d      = HEADER ^ waveform_sel ^ {4'h0, freq_sel};
          byte_idx_d = 2'd0;
          bit_idx_d  = 3'd0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (byte_idx_q == 2'd3) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            bit_idx_d  = 3'd0;
            state_d    = S_START;
          end
        end
      end
    endcase
  end

  // Byte to be on the line in the next cycle, taken from the next-state snapshot.
  always_comb begin
    cur_byte_d = HEADER;
    case (byte_idx_d)
      2'd0: cur_byte_d = HEADER;
      2'd1: cur_byte_d = wave_d;
      2'd2: cur_byte_d = {4'h0, freq_d};
      2'd3: cur_byte_d = chk_d;
    endcase
  end

  // TX level is registered from the next state so the pin never glitches.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      S_IDLE:  txd_d = 1'b1;
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = cur_byte_d[bit_idx_d];
      S_STOP:  txd_d = 1'b1;
    endcase
  end

  // State registers with synchronous reset; a reset mid-frame drops the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      wave_q     <= 8'h00;
      freq_q     <= 4'h0;
      chk_q      <= 8'h00;
      done_q     <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      wave_q     <= wave_d;
      freq_q     <= freq_d;
      chk_q      <= chk_d;
      done_q     <= done_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_status_tx.sv
// Bench for uart_status_tx at 10 clocks per bit. Expected line levels come
// from a frame model: 4 bytes, each start(0) + 8 data LSB first + stop(1).
module tb_uart_status_tx;

  localparam int CPB   = 10;
  localparam int FRAME = 40 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       report_req;
  logic [7:0] waveform_sel;
  logic [3:0] freq_sel;
  logic       uart_txd;
  logic       busy;
  logic       done;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_b [4];
  int         chg_cyc;
  int         extra_a;
  int         extra_b;
  logic [7:0] w_new;

  uart_status_tx #(
    .CLK_HZ  (1000000),
    .BIT_RATE(100000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .report_req  (report_req),
    .waveform_sel(waveform_sel),
    .freq_sel    (freq_sel),
    .uart_txd    (uart_txd),
    .busy        (busy),
    .done        (done)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_model(input logic [7:0] w, input logic [3:0] f);
    exp_b[0] = 8'hA5;
    exp_b[1] = w;
    exp_b[2] = {4'h0, f};
    exp_b[3] = exp_b[0] ^ exp_b[1] ^ exp_b[2];
  endtask

  // Line level c cycles after the accepting edge.
  function automatic logic model_bit(input int c);
    int k;
    int pos;
    k   = c / CPB;
    pos = k % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return exp_b[k / 10][pos - 1];
  endfunction

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, " busy"}, {7'b0, busy}, 8'h00);
      chk({tag, " done"}, {7'b0, done}, 8'h00);
      chk({tag, " txd"},  {7'b0, uart_txd}, 8'h01);
    end
  endtask

  // One full frame. issue=0 means the request was already raised in the
  // previous done cycle. chain=1 raises the next request in this done cycle.
  task automatic run_frame(input logic [7:0] w, input logic [3:0] f, input bit issue,
                           input bit chain, input logic [7:0] w2, input logic [3:0] f2);
    logic [7:0] dec [4];
    int k;
    for (int b = 0; b < 4; b++) dec[b] = 8'h00;
    if (issue) begin
      @(negedge clk);
      waveform_sel = w;
      freq_sel     = f;
      report_req   = 1'b1;
    end
    set_model(w, f);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      report_req = 1'b0;
      chk($sformatf("txd c%0d", c), {7'b0, uart_txd}, {7'b0, model_bit(c)});
      chk($sformatf("busy c%0d", c), {7'b0, busy}, 8'h01);
      chk($sformatf("done c%0d", c), {7'b0, done}, 8'h00);
      k = c / CPB;
      if ((c % CPB) == CPB / 2 && (k % 10) >= 1 && (k % 10) <= 8)
        dec[k / 10][(k % 10) - 1] = uart_txd;
      if (c == chg_cyc) waveform_sel = w_new;
      if (c == extra_a || c == extra_b) report_req = 1'b1;
    end
    @(negedge clk);
    report_req = 1'b0;
    chk("done pulse", {7'b0, done}, 8'h01);
    chk("busy in done cycle", {7'b0, busy}, 8'h00);
    chk("txd in done cycle", {7'b0, uart_txd}, 8'h01);
    for (int b = 0; b < 4; b++) chk($sformatf("decoded byte %0d", b), dec[b], exp_b[b]);
    if (chain) begin
      waveform_sel = w2;
      freq_sel     = f2;
      report_req   = 1'b1;
    end else begin
      @(negedge clk);
      chk("done after pulse", {7'b0, done}, 8'h00);
      chk("busy after frame", {7'b0, busy}, 8'h00);
    end
  endtask

  initial begin
    logic [7:0] rw;
    logic [3:0] rf;
    rst          = 1'b1;
    report_req   = 1'b0;
    waveform_sel = 8'h00;
    freq_sel     = 4'h0;
    chg_cyc      = -1;
    extra_a      = -1;
    extra_b      = -1;
    w_new        = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset txd",  {7'b0, uart_txd}, 8'h01);
    chk("reset busy", {7'b0, busy}, 8'h00);
    chk("reset done", {7'b0, done}, 8'h00);
    rst = 1'b0;
    idle_check("idle after reset", 5);

    // Basic frame and all-zero frame.
    run_frame(8'h3C, 4'h5, 1'b1, 1'b0, 8'h00, 4'h0);
    run_frame(8'h00, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0);

    // Input change mid-frame must not reach the line.
    chg_cyc = 50;
    w_new   = 8'hFF;
    run_frame(8'h11, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0);
    chg_cyc = -1;

    // Requests while busy are dropped, not queued.
    extra_a = 20;
    extra_b = 200;
    rw = 8'($urandom);
    rf = 4'($urandom);
    run_frame(rw, rf, 1'b1, 1'b0, 8'h00, 4'h0);
    extra_a = -1;
    extra_b = -1;
    idle_check("idle after ignored reqs", 20);

    // Reset at cycle 150 abandons the frame.
    @(negedge clk);
    waveform_sel = 8'h5A;
    freq_sel     = 4'h3;
    report_req   = 1'b1;
    for (int c = 0; c <= 150; c++) begin
      @(negedge clk);
      report_req = 1'b0;
      if (c == 150) rst = 1'b1;
    end
    @(negedge clk);
    chk("rst mid txd",  {7'b0, uart_txd}, 8'h01);
    chk("rst mid busy", {7'b0, busy}, 8'h00);
    chk("rst mid done", {7'b0, done}, 8'h00);
    rst = 1'b0;
    idle_check("after mid reset", 60);
    rw = 8'($urandom);
    rf = 4'($urandom);
    run_frame(rw, rf, 1'b1, 1'b0, 8'h00, 4'h0);

    // Request in the done cycle starts the next frame with no gap.
    rw = 8'($urandom);
    rf = 4'($urandom);
    run_frame(rw, rf, 1'b1, 1'b1, 8'h7E, 4'hA);
    run_frame(8'h7E, 4'hA, 1'b0, 1'b0, 8'h00, 4'h0);

    // Random frames with a random mid-frame input change.
    for (int i = 0; i < 3; i++) begin
      rw      = 8'($urandom);
      rf      = 4'($urandom);
      chg_cyc = int'($urandom_range(0, FRAME - 1));
      w_new   = 8'($urandom);
      run_frame(rw, rf, 1'b1, 1'b0, 8'h00, 4'h0);
    end
    chg_cyc = -1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
